// File: rtl/hs_instr_controller.sv
// ---------------------------------------------------------------------------
// hs_instr_controller
//
// Sequential instruction-decode controller. Accepts one instruction word per
// valid/ready handshake, registers its decoded fields and presents them to the
// ALU / register file with a second valid/ready handshake. Load and store
// instructions are then walked through a memory request/acknowledge exchange
// guarded by a timeout, and loads finish with a one-cycle register-file write.
//
// Optional build macro:
//   HS_CTRL_SIGN_EXT_EN  defined   -> imm is sign-extended from payload MSB
//                        undefined -> imm is zero-extended (default)
//
// Parameters:
//   DATA_W       instruction word width and imm output width
//   REG_W        register address field width (rd, rs, rt)
//   FX_W         function field width, also the ALU op select width
//   MEM_TIMEOUT  cycles allowed in MEM_WAIT without mem_ack (>= 1)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr        instruction word
//   instr_valid  instr is valid
//   instr_ready  controller can accept instr (IDLE only)
//   dec_valid    decoded fields valid (ISSUE)
//   dec_ready    downstream accepts decoded fields
//   ri           1 = immediate form, 0 = register form
//   rd, rs, rt   register addresses
//   fx           function field
//   imm          extended immediate
//   alu_opsel    ALU operation select
//   we1          load in progress
//   we2          store in progress
//   mem_req      memory request
//   mem_ack      memory acknowledge
//   rf_we        register-file write enable, one-cycle pulse
//   err          memory timeout, one-cycle pulse
// ---------------------------------------------------------------------------
module hs_instr_controller #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 6,
    parameter int FX_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic              ri,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [FX_W-1:0]   fx,
    output logic [DATA_W-1:0] imm,
    output logic [FX_W-1:0]   alu_opsel,
    output logic              we1,
    output logic              we2,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic              err
);

    localparam int IMM_W = DATA_W - 1 - 2*REG_W - FX_W;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    // rt is carved out of the top of the payload, so the payload must be at
    // least one register field wide.
    if (IMM_W < REG_W) begin : g_bad_imm_w
        $error("hs_instr_controller: IMM_W (%0d) must be >= REG_W (%0d)", IMM_W, REG_W);
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("hs_instr_controller: MEM_TIMEOUT must be >= 1");
    end

    localparam logic [FX_W-1:0] FX_LOAD  = {{(FX_W-1){1'b1}}, 1'b0};
    localparam logic [FX_W-1:0] FX_STORE = {FX_W{1'b1}};
    localparam logic [FX_W-1:0] OP_ADD   = '0;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_WB       = 2'd3;

    // The counter holds the number of MEM_WAIT cycles already spent, so the
    // last permitted cycle is the one where it equals MEM_TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Incoming instruction fields
    logic              in_ri;
    logic [REG_W-1:0]  in_rd;
    logic [REG_W-1:0]  in_rs;
    logic [FX_W-1:0]   in_fx;
    logic [IMM_W-1:0]  in_payload;
    logic              in_is_mem;
    logic [REG_W-1:0]  in_rt;
    logic [DATA_W-1:0] in_imm;
    logic [FX_W-1:0]   in_opsel;

    logic is_load;
    logic is_store;
    logic is_mem;
    logic timeout_hit;

    assign in_ri      = instr[DATA_W-1];
    assign in_rd      = instr[DATA_W-2 -: REG_W];
    assign in_rs      = instr[DATA_W-2-REG_W -: REG_W];
    assign in_fx      = instr[DATA_W-2-2*REG_W -: FX_W];
    assign in_payload = instr[IMM_W-1:0];
    assign in_is_mem  = (in_fx == FX_LOAD) || (in_fx == FX_STORE);

    always_comb begin
        in_rt    = '0;
        in_imm   = '0;
        in_opsel = in_is_mem ? OP_ADD : in_fx;
        if (in_ri) begin
`ifdef HS_CTRL_SIGN_EXT_EN
            in_imm = {{(DATA_W-IMM_W){in_payload[IMM_W-1]}}, in_payload};
`else
            in_imm = {{(DATA_W-IMM_W){1'b0}}, in_payload};
`endif
        end else begin
            in_rt = in_payload[IMM_W-1 -: REG_W];
        end
    end

    // The registered fx alone tells the later states which kind of
    // instruction is in flight, so no separate opcode class is stored.
    assign is_load     = (fx == FX_LOAD);
    assign is_store    = (fx == FX_STORE);
    assign is_mem      = is_load || is_store;
    assign timeout_hit = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dec_ready) begin
                        if (is_mem) begin
                            state <= S_MEM_WAIT;
                            cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    // An acknowledge on the final cycle still wins over the timeout.
                    if (mem_ack) begin
                        state <= is_load ? S_WB : S_IDLE;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded fields only change on acceptance, which keeps them stable under
    // backpressure and through the memory and write-back phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ri        <= 1'b0;
            rd        <= '0;
            rs        <= '0;
            rt        <= '0;
            fx        <= '0;
            imm       <= '0;
            alu_opsel <= '0;
        end else if (state == S_IDLE && instr_valid) begin
            ri        <= in_ri;
            rd        <= in_rd;
            rs        <= in_rs;
            rt        <= in_rt;
            fx        <= in_fx;
            imm       <= in_imm;
            alu_opsel <= in_opsel;
        end
    end

    // instr_ready is gated by rst_n because the reset state is IDLE, yet the
    // controller must not advertise readiness while held in reset.
    assign instr_ready = rst_n && (state == S_IDLE);
    assign dec_valid   = (state == S_ISSUE);
    assign mem_req     = (state == S_MEM_WAIT);
    assign we1         = mem_req && is_load;
    assign we2         = mem_req && is_store;
    assign rf_we       = ((state == S_ISSUE) && dec_ready && !is_mem) || (state == S_WB);
    assign err         = mem_req && !mem_ack && timeout_hit;

endmodule

// File: tb/tb_hs_instr_controller.sv
// ---------------------------------------------------------------------------
// tb_hs_instr_controller
//
// Scoreboard bench for hs_instr_controller. The driver issues directed and
// random instructions, picks how long the memory takes to acknowledge and how
// long downstream stalls, and pushes the expected outcome of each accepted
// instruction into a queue. An independent monitor on the falling edge pops
// the queue and checks decode fields, handshakes, memory phase length, err
// and rf_we against that expectation.
// ---------------------------------------------------------------------------
module tb_hs_instr_controller;

    localparam int DATA_W      = 32;
    localparam int REG_W       = 6;
    localparam int FX_W        = 4;
    localparam int MEM_TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              dec_valid;
    logic              dec_ready;
    logic              ri;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [FX_W-1:0]   fx;
    logic [DATA_W-1:0] imm;
    logic [FX_W-1:0]   alu_opsel;
    logic              we1;
    logic              we2;
    logic              mem_req;
    logic              mem_ack;
    logic              rf_we;
    logic              err;

    hs_instr_controller #(
        .DATA_W     (DATA_W),
        .REG_W      (REG_W),
        .FX_W       (FX_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .ri         (ri),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .fx         (fx),
        .imm        (imm),
        .alu_opsel  (alu_opsel),
        .we1        (we1),
        .we2        (we2),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .rf_we      (rf_we),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = ALU op, 1 = load, 2 = store
    typedef struct {
        logic        ri;
        logic [5:0]  rd;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [3:0]  fx;
        logic [3:0]  opsel;
        logic [31:0] imm;
        int          kind;
        int          memCycles;
        bit          expErr;
        bit          expWb;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    exp_t cur;
    int   monMode;
    int   memCnt;
    bit   monPause;
    int   vectors;
    int   miscompares;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode written from the field layout with plain arithmetic:
    // ri | rd(6) | rs(6) | fx(4) | payload(15).
    function automatic exp_t model(input logic [31:0] w, input int d);
        exp_t e;
        longint unsigned u;
        longint unsigned p;
        u = 64'(w);
        p = u % 32768;
        e.ri = 1'(u / 64'd2147483648);
        e.rd = 6'((u / 64'd33554432) % 64);
        e.rs = 6'((u / 64'd524288) % 64);
        e.fx = 4'((u / 64'd32768) % 16);
        e.rt = e.ri ? 6'd0 : 6'(p / 512);
        if (!e.ri) begin
            e.imm = 32'd0;
        end else begin
`ifdef HS_CTRL_SIGN_EXT_EN
            e.imm = (p >= 16384) ? 32'(p + 64'hFFFF_8000) : 32'(p);
`else
            e.imm = 32'(p);
`endif
        end
        e.kind  = (e.fx == 4'd14) ? 1 : (e.fx == 4'd15) ? 2 : 0;
        e.opsel = (e.kind == 0) ? e.fx : 4'd0;
        if (e.kind == 0) begin
            e.memCycles = 0;
            e.expErr    = 1'b0;
            e.expWb     = 1'b0;
        end else if (d <= MEM_TIMEOUT) begin
            e.memCycles = d;
            e.expErr    = 1'b0;
            e.expWb     = (e.kind == 1);
        end else begin
            e.memCycles = MEM_TIMEOUT;
            e.expErr    = 1'b1;
            e.expWb     = 1'b0;
        end
        return e;
    endfunction

    task automatic idleCycle();
        instr_valid = 1'($urandom_range(0, 1));
        instr       = $urandom;
        dec_ready   = 1'($urandom_range(0, 1));
        mem_ack     = 1'b0;
        @(posedge clk); #1;
    endtask

    // Offers one instruction, stalls downstream for bp cycles in ISSUE, then
    // acknowledges memory on the d-th MEM_WAIT cycle (d > MEM_TIMEOUT = never).
    task automatic applyStimulus(input logic [31:0] w, input int d, input int bp);
        int guard;
        int cnt;
        int left;
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 100) begin
            idleCycle();
            guard++;
        end
        if (instr_ready !== 1'b1) begin
            checkOutput("wait_ready", instr_ready, 1);
            return;
        end
        instr       = w;
        instr_valid = 1'b1;
        dec_ready   = 1'($urandom_range(0, 1));
        mem_ack     = 1'($urandom_range(0, 1));
        expQ.push_back(model(w, d));
        @(posedge clk); #1;
        left  = bp;
        guard = 0;
        while (dec_valid === 1'b1 && guard < 50) begin
            instr_valid = 1'b1;
            instr       = $urandom;
            dec_ready   = (left == 0);
            if (left > 0) left--;
            mem_ack     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) checkOutput("issue_stuck", dec_valid, 0);
        cnt   = 0;
        guard = 0;
        while (mem_req === 1'b1 && guard < 60) begin
            cnt++;
            mem_ack     = (cnt == d);
            instr_valid = 1'($urandom_range(0, 1));
            instr       = $urandom;
            dec_ready   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 60) checkOutput("mem_stuck", mem_req, 0);
        mem_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!monPause) begin
            case (monMode)
                0: begin
                    if (dec_valid === 1'b1) begin
                        if (expQ.size() == 0) begin
                            checkOutput("dec_valid_unexpected", dec_valid, 0);
                        end else begin
                            monExp = expQ[0];
                            checkOutput("fields", {ri, rd, rs, fx, rt, alu_opsel},
                                        {monExp.ri, monExp.rd, monExp.rs, monExp.fx, monExp.rt, monExp.opsel});
                            checkOutput("imm", imm, monExp.imm);
                            checkOutput("instr_ready_busy", instr_ready, 0);
                            if (dec_ready === 1'b1) begin
                                void'(expQ.pop_front());
                                if (monExp.kind == 0) begin
                                    checkOutput("alu_rf_we", rf_we, 1);
                                    monMode = 3;
                                end else begin
                                    checkOutput("issue_rf_we", rf_we, 0);
                                    cur     = monExp;
                                    memCnt  = 0;
                                    monMode = 1;
                                end
                            end else begin
                                checkOutput("bp_rf_we", rf_we, 0);
                            end
                        end
                    end else begin
                        if (rf_we === 1'b1)   checkOutput("spurious_rf_we", rf_we, 0);
                        if (mem_req === 1'b1) checkOutput("spurious_mem_req", mem_req, 0);
                        if (err === 1'b1)     checkOutput("spurious_err", err, 0);
                    end
                end
                1: begin
                    memCnt++;
                    checkOutput("mem_phase", {mem_req, we1, we2, dec_valid, rf_we},
                                {1'b1, (cur.kind == 1), (cur.kind == 2), 1'b0, 1'b0});
                    if (mem_req !== 1'b1) begin
                        monMode = 0;
                    end else if (memCnt >= cur.memCycles) begin
                        checkOutput("err_final", err, cur.expErr);
                        monMode = cur.expWb ? 2 : 3;
                    end else begin
                        checkOutput("err_early", err, 0);
                    end
                end
                2: begin
                    checkOutput("wb", {rf_we, mem_req, dec_valid, rd}, {1'b1, 1'b0, 1'b0, cur.rd});
                    monMode = 3;
                end
                default: begin
                    checkOutput("back_idle", {instr_ready, mem_req, rf_we, err}, 4'b1000);
                    monMode = 0;
                end
            endcase
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          d;
        int          bp;
        int          guard;
        vectors     = 0;
        miscompares = 0;
        monMode     = 0;
        memCnt      = 0;
        monPause    = 1'b1;
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        dec_ready   = 1'b0;
        mem_ack     = 1'b0;

        #12;
        checkOutput("reset_state", {instr_ready, dec_valid, mem_req, we1, we2, rf_we, err, ri, rd, fx},
                    17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", instr_ready, 1);
        monPause = 1'b0;

        $display("[TB] directed vectors");
        applyStimulus(32'hBD547E00, 1, 0);
        applyStimulus(32'h7AA87E00, 1, 0);
        w = {1'b0, 6'd5, 6'd9, 4'hE, 15'h0123};
        applyStimulus(w, 3, 0);
        w = {1'b1, 6'd9, 6'd3, 4'hF, 15'h4000};
        applyStimulus(w, 99, 0);
        w = {1'b1, 6'd17, 6'd33, 4'h6, 15'h5A5A};
        applyStimulus(w, 1, 4);
        w = {1'b0, 6'd44, 6'd12, 4'hE, 15'h7FFF};
        applyStimulus(w, MEM_TIMEOUT, 2);
        w = {1'b1, 6'd63, 6'd0, 4'hF, 15'h0001};
        applyStimulus(w, 1, 0);
        w = {1'b1, 6'd1, 6'd62, 4'hE, 15'h6000};
        applyStimulus(w, MEM_TIMEOUT + 1, 1);

        $display("[TB] random vectors");
        for (int i = 0; i < 150; i++) begin
            w = $urandom;
            d = int'($urandom_range(0, 9));
            if (d < 3)      w[18:15] = 4'hE;
            else if (d < 5) w[18:15] = 4'hF;
            d  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(MEM_TIMEOUT + 1, MEM_TIMEOUT + 5))
                                            : int'($urandom_range(1, MEM_TIMEOUT));
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            applyStimulus(w, d, bp);
        end

        instr_valid = 1'b0;
        dec_ready   = 1'b0;
        mem_ack     = 1'b0;
        guard = 0;
        while ((expQ.size() != 0 || monMode != 0) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("drain", expQ.size(), 0);

        $display("[TB] reset in the middle of MEM_WAIT");
        monPause = 1'b1;
        @(posedge clk); #1;
        w           = {1'b0, 6'd7, 6'd2, 4'hE, 15'h1234};
        instr       = w;
        instr_valid = 1'b1;
        dec_ready   = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_reset_mem", {mem_req, we1, we2}, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", {mem_req, we1, we2, dec_valid, instr_ready, rf_we, err}, 7'd0);
        @(posedge clk); #1;
        checkOutput("reset_fields", {ri, rd, rs, fx, rt, imm, alu_opsel}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_ready", {instr_ready, dec_valid, mem_req}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
